// File: rtl/pc_sequencer.sv
// Program-counter stage feeding instruction fetch: sequential advance, redirect,
// call/return through a hardware return-address stack, stall and terminal halt.
module pc_sequencer #(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter int unsigned STACK_DEPTH = 8,
  parameter int unsigned DEPTH_W     = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               halt_req,
  input  logic               redirect,
  input  logic [15:0]        redirect_target,
  input  logic               call,
  input  logic [15:0]        call_target,
  input  logic               ret,
  output logic [15:0]        pc,
  output logic [DEPTH_W-1:0] depth,
  output logic               halted,
  output logic               stack_overflow,
  output logic               stack_underflow
);

  localparam int unsigned PC_W  = 16;
  localparam int unsigned PTR_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  typedef enum logic {
    ST_RUN,
    ST_HALTED
  } state_t;

  state_t             state_q, state_d;
  logic [PC_W-1:0]    pc_d;
  logic [DEPTH_W-1:0] depth_d;
  logic               ovf_d, unf_d;
  logic               push;
  logic [PC_W-1:0]    pc_inc;
  logic [PTR_W-1:0]   wr_idx, top_idx;
  logic               stack_empty, stack_full;
  logic [PC_W-1:0]    stack_mem [STACK_DEPTH];

  assign pc_inc      = pc + PC_W'(1);
  assign wr_idx      = PTR_W'(depth);
  assign top_idx     = PTR_W'(depth - DEPTH_W'(1));
  assign stack_empty = (depth == '0);
  assign stack_full  = (depth == DEPTH_W'(STACK_DEPTH));

  // State, PC, depth and sticky flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= ST_RUN;
      pc              <= RESET_PC;
      depth           <= '0;
      halted          <= 1'b0;
      stack_overflow  <= 1'b0;
      stack_underflow <= 1'b0;
    end else begin
      state_q         <= state_d;
      pc              <= pc_d;
      depth           <= depth_d;
      halted          <= (state_d == ST_HALTED);
      stack_overflow  <= ovf_d;
      stack_underflow <= unf_d;
    end
  end

  // Return-address storage; contents are don't-care after reset
  always_ff @(posedge clk) begin
    if (push) stack_mem[wr_idx] <= pc_inc;
  end

  // Next-state and single prioritized action per unstalled RUN cycle
  always_comb begin
    state_d = state_q;
    pc_d    = pc;
    depth_d = depth;
    ovf_d   = stack_overflow;
    unf_d   = stack_underflow;
    push    = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (halt_req) begin
          state_d = ST_HALTED;
        end else if (!stall) begin
          if (ret) begin
            if (!stack_empty) begin
              pc_d    = stack_mem[top_idx];
              depth_d = depth - DEPTH_W'(1);
            end else begin
              pc_d  = pc_inc;
              unf_d = 1'b1;
            end
          end else if (call) begin
            pc_d = call_target;
            if (!stack_full) begin
              push    = 1'b1;
              depth_d = depth + DEPTH_W'(1);
            end else begin
              ovf_d = 1'b1;
            end
          end else if (redirect) begin
            pc_d = redirect_target;
          end else begin
            pc_d = pc_inc;
          end
        end
      end
      ST_HALTED: begin
        state_d = ST_HALTED;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Program-counter stage directly upstream of the instruction fetch stage.
- Holds the 16-bit PC that fetch uses to index instruction memory.
- Each cycle it advances sequentially or redirects: branch/jump target, call with hardware return-address stack, or return.
- Supports stall from downstream and a terminal halt state.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset
STACK_DEPTH, 8, number of return-address stack entries (power of two, 2..16)
DEPTH_W, 4, width of depth output; must satisfy 2^DEPTH_W > STACK_DEPTH

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous active-high reset
stall  input  1  hold PC and stack this cycle
halt_req  input  1  enter HALTED state
redirect  input  1  branch taken or jump; load redirect_target
redirect_target  input  16  redirect destination
call  input  1  push return address, load call_target
call_target  input  16  call destination
ret  input  1  pop return address into PC
pc  output  16  current PC, fed to fetch
depth  output  DEPTH_W  number of valid stack entries
halted  output  1  high while in HALTED
stack_overflow  output  1  sticky: call issued with stack full
stack_underflow  output  1  sticky: ret issued with stack empty

Behaviour:
- Reset (async, any time, including mid-call or mid-halt):
  - pc=RESET_PC, depth=0, halted=0, both sticky flags=0, state=RUN.
  - Stack contents are don't-care after reset.
- State machine has two states, RUN and HALTED.
  - RUN -> HALTED on a clock edge with halt_req=1, regardless of stall. pc holds; no push/pop that edge.
  - HALTED is exited only by reset. All inputs are ignored; pc, depth and flags hold.
  - halted is high in the cycle after the halt edge.
- On each RUN edge with halt_req=0 and stall=1: pc, depth and stack hold, and all requests are dropped. Requests are single-cycle qualified; the requester re-asserts them after the stall.
- On each RUN edge with halt_req=0 and stall=0, exactly one action is taken, in this priority order:
  1. ret, depth>0: pc <= stack[top], depth <= depth-1.
  2. ret, depth=0: pc <= pc+1, stack_underflow <= 1.
  3. call, depth<STACK_DEPTH: stack[depth] <= pc+1, depth <= depth+1, pc <= call_target.
  4. call, depth=STACK_DEPTH: pc <= call_target, no push, stack_overflow <= 1.
  5. redirect: pc <= redirect_target.
  6. otherwise: pc <= pc+1.
- Arithmetic and conflict rules:
  - pc+1 is modulo 2^16 (16'hFFFF -> 16'h0000), including the pushed return address.
  - ret+call together: ret wins, call is discarded.
  - call+redirect together: call wins.
- Latency is one cycle from request to new pc. All outputs are registered; there is no combinational path from inputs to outputs.
- Sticky flags clear only on reset.

Test Plan:
- Reset then 5 free-running cycles, RESET_PC=16'h0000 -> pc 0,1,2,3,4,5; depth=0; halted=0.
- pc=16'h0010, call to 16'h0080, 3 increments, ret -> pc 0x80,0x81,0x82,0x83, then 0x11; depth 1 then 0.
- pc=16'h0020, stall high 3 cycles with redirect to 16'h0040 asserted in the same cycles -> pc stays 0x20 for 3 cycles, then increments to 0x21 (redirect dropped).
- 9 nested calls with STACK_DEPTH=8 to targets 0x100..0x108 -> depth saturates at 8, stack_overflow=1 after the 9th call, pc=0x108. Then 9 rets: the first 8 return the correct addresses in LIFO order; the 9th gives pc+1 and stack_underflow=1.
- pc=16'hFFFF with no request -> pc=16'h0000. Call at pc=16'hFFFF pushes 16'h0000.
- halt_req at pc=0x30 with call asserted -> halted=1, pc stays 0x30, depth unchanged, later requests ignored. Reset asserted mid-cycle -> pc=RESET_PC immediately, halted=0.
